// File: rtl/scan_pkg.sv
// Shared types and sizes for the channel scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum (GAP exists only when SCAN_BLANKING_EN is defined),
//           channel count NUM_CH and select width SEL_W.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1
`ifdef SCAN_BLANKING_EN
        ,
        ST_GAP  = 2'd2
`endif
    } scan_state_t;

endpackage

// File: rtl/channel_scan_sequencer_if.sv
// Control/status bundle between a scan requester and the channel scan sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start/stop are level requests sampled by the sequencer.
// Ports: start, stop, continuous, mask, dwell (requester -> sequencer);
//        sel, sel_en, busy, done (sequencer -> requester / decoder).
interface channel_scan_sequencer_if
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
);
    logic                 start;
    logic                 stop;
    logic                 continuous;
    logic [NUM_CH-1:0]    mask;
    logic [DWELL_W-1:0]   dwell;
    logic [SEL_W-1:0]     sel;
    logic                 sel_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, continuous, mask, dwell,
        input  sel, sel_en, busy, done
    );

    modport slave (
        input  start, stop, continuous, mask, dwell,
        output sel, sel_en, busy, done
    );
endinterface

// File: rtl/next_channel_finder.sv
// Combinational search over a channel mask: next set bit above an index, wrap flag, lowest set bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: mask_i/idx_i in; next_idx_o (valid when !wrap_o), wrap_o (no higher set bit), low_idx_o.
module next_channel_finder
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic [SEL_W-1:0]  next_idx_o,
    output logic              wrap_o,
    output logic [SEL_W-1:0]  low_idx_o
);

    // Walk downward so the last hit written is the lowest qualifying bit.
    always_comb begin
        next_idx_o = '0;
        wrap_o     = 1'b1;
        low_idx_o  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_idx_o = SEL_W'(i);
                if (i > int'(idx_i)) begin
                    next_idx_o = SEL_W'(i);
                    wrap_o     = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Steps a 3-to-8 decoder select through the enabled channels of a mask, holding each for a dwell time.
// Latency: first channel driven 1 cycle after start; stop/completion take effect 1 cycle later.
// Backpressure: none; start is ignored while busy, stop aborts from any active state.
// Ports: clk, rst_n (async active-low); bus (slave modport): start/stop/continuous/mask/dwell in,
//        sel/sel_en/busy/done out, all outputs registered.
// Build option: SCAN_BLANKING_EN inserts one GAP cycle (sel_en=0, sel already advanced) per channel change.
module channel_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
)(
    input  logic                      clk,
    input  logic                      rst_n,
    channel_scan_sequencer_if.slave   bus
);

    scan_state_t          state_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 sel_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DWELL_W-1:0]   cnt_q;      // cycles remaining on the current channel, minus one
    logic [DWELL_W-1:0]   dwell_q;
    logic [NUM_CH-1:0]    mask_q;
    logic                 cont_q;

    logic [NUM_CH-1:0]    fnd_mask_d;
    logic [SEL_W-1:0]     fnd_next_d;
    logic                 fnd_wrap_d;
    logic [SEL_W-1:0]     fnd_low_d;
    logic [SEL_W-1:0]     adv_idx_d;

    // In IDLE the finder looks at the live mask so the first channel is known at start;
    // while scanning it only ever sees the latched copy.
    assign fnd_mask_d = (state_q == ST_IDLE) ? bus.mask : mask_q;
    assign adv_idx_d  = fnd_wrap_d ? fnd_low_d : fnd_next_d;

    next_channel_finder u_finder (
        .mask_i     (fnd_mask_d),
        .idx_i      (sel_q),
        .next_idx_o (fnd_next_d),
        .wrap_o     (fnd_wrap_d),
        .low_idx_o  (fnd_low_d)
    );

    // dwell=0 is treated as a one-cycle hold.
    function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.mask != '0) begin
                            mask_q   <= bus.mask;
                            dwell_q  <= bus.dwell;
                            cont_q   <= bus.continuous;
                            cnt_q    <= reload(bus.dwell);
                            sel_q    <= fnd_low_d;
                            sel_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SCAN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (bus.stop) begin
                        state_q  <= ST_IDLE;
                        sel_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (fnd_wrap_d && !cont_q) begin
                        // single pass finished; sel keeps the last channel
                        state_q  <= ST_IDLE;
                        sel_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        sel_q <= adv_idx_d;
`ifdef SCAN_BLANKING_EN
                        // a single-channel rescan is not a channel change, so no blanking
                        if (adv_idx_d != sel_q) begin
                            state_q  <= ST_GAP;
                            sel_en_q <= 1'b0;
                        end else begin
                            cnt_q <= reload(dwell_q);
                        end
`else
                        cnt_q <= reload(dwell_q);
`endif
                    end
                end

`ifdef SCAN_BLANKING_EN
                ST_GAP: begin
                    if (bus.stop) begin
                        state_q  <= ST_IDLE;
                        sel_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q  <= ST_SCAN;
                        sel_en_q <= 1'b1;
                        cnt_q    <= reload(dwell_q);
                    end
                end
`endif

                default: begin
                    state_q  <= ST_IDLE;
                    sel_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel    = sel_q;
    assign bus.sel_en = sel_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Randomized self-checking bench for channel_scan_sequencer against a trace-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_channel_scan_sequencer;
    import scan_pkg::*;

    localparam int DWELL_W = 8;

    logic clk;
    logic rst_n;

    channel_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    channel_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] model_sel;
    int         n_tests;
    int         n_fail;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected per-cycle outputs, starting the cycle after start is sampled,
    // ending with the first idle cycle.
    task automatic build_trace(input logic [7:0] m, input int dw, input logic c, input int stop_after);
        exp_t e;
        int   d;
        int   prev;
        exp_q.delete();
        if (m == 8'h00) begin
            e.sel = model_sel; e.en = 1'b0; e.busy = 1'b0; e.done = 1'b1;
            exp_q.push_back(e);
            return;
        end
        d    = (dw == 0) ? 1 : dw;
        prev = -1;
        do begin
            for (int ch = 0; ch < 8; ch++) begin
                if (m[ch]) begin
`ifdef SCAN_BLANKING_EN
                    if (prev >= 0 && prev != ch) begin
                        e.sel = 3'(ch); e.en = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                        exp_q.push_back(e);
                    end
`endif
                    for (int k = 0; k < d; k++) begin
                        e.sel = 3'(ch); e.en = 1'b1; e.busy = 1'b1; e.done = 1'b0;
                        exp_q.push_back(e);
                    end
                    prev = ch;
                end
            end
        end while (c && exp_q.size() < stop_after);

        if (stop_after > 0 && stop_after <= exp_q.size()) begin
            while (exp_q.size() > stop_after) void'(exp_q.pop_back());
            e = exp_q[$];
            e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        end else begin
            e = exp_q[$];
            e.en = 1'b0; e.busy = 1'b0; e.done = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // stop_after=N asserts stop while the Nth active cycle is on the outputs.
    task automatic run_scan(input logic [7:0] m, input int dw, input logic c,
                            input int stop_after, input string name);
        int n;
        build_trace(m, dw, c, (m == 8'h00) ? 0 : stop_after);
        n = exp_q.size();
        @(negedge clk);
        bus.mask       = m;
        bus.dwell      = DWELL_W'(dw);
        bus.continuous = c;
        bus.start      = 1'b1;
        bus.stop       = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s[%0d].sel", name, i),    32'(bus.sel),    32'(exp_q[i].sel));
            check_eq($sformatf("%s[%0d].sel_en", name, i), 32'(bus.sel_en), 32'(exp_q[i].en));
            check_eq($sformatf("%s[%0d].busy", name, i),   32'(bus.busy),   32'(exp_q[i].busy));
            check_eq($sformatf("%s[%0d].done", name, i),   32'(bus.done),   32'(exp_q[i].done));
            if (i < n - 1) begin
                // noise on the request inputs while busy must be ignored
                bus.start      = 1'($urandom_range(0, 1));
                bus.mask       = 8'($urandom);
                bus.dwell      = DWELL_W'($urandom);
                bus.continuous = 1'($urandom_range(0, 1));
                bus.stop       = (stop_after > 0 && i == stop_after - 1);
            end else begin
                bus.start = 1'b0;
                bus.stop  = 1'b0;
            end
        end
        @(negedge clk);
        check_eq({name, ".post_done"},   32'(bus.done),   32'd0);
        check_eq({name, ".post_sel_en"}, 32'(bus.sel_en), 32'd0);
        check_eq({name, ".post_busy"},   32'(bus.busy),   32'd0);
        model_sel = exp_q[n-1].sel;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        int         dw;
        logic       c;
        int         sa;
        int         r;
        bit         saw_done;

        n_tests        = 0;
        n_fail         = 0;
        model_sel      = '0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.mask       = '0;
        bus.dwell      = '0;

        repeat (3) @(negedge clk);
        check_eq("rst.sel",    32'(bus.sel),    32'd0);
        check_eq("rst.sel_en", 32'(bus.sel_en), 32'd0);
        check_eq("rst.busy",   32'(bus.busy),   32'd0);
        check_eq("rst.done",   32'(bus.done),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(8'hA5, 2, 1'b0, 0, "a5_pass");
        run_scan(8'h81, 1, 1'b1, 9, "81_cont_stop");
        run_scan(8'h00, 3, 1'b0, 0, "empty");
        run_scan(8'h10, 0, 1'b0, 0, "single_dw0");
        run_scan(8'hFF, 1, 1'b0, 3, "ff_stop");
        run_scan(8'h08, 2, 1'b1, 7, "single_cont");

        // start and stop together in IDLE: nothing happens
        @(negedge clk);
        bus.mask  = 8'h0F;
        bus.dwell = 8'd1;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        check_eq("startstop.busy",   32'(bus.busy),   32'd0);
        check_eq("startstop.done",   32'(bus.done),   32'd0);
        check_eq("startstop.sel_en", 32'(bus.sel_en), 32'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // asynchronous reset in the middle of a scan
        @(negedge clk);
        bus.mask       = 8'hFF;
        bus.dwell      = 8'd4;
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("midrst.pre_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.sel",    32'(bus.sel),    32'd0);
        check_eq("midrst.sel_en", 32'(bus.sel_en), 32'd0);
        check_eq("midrst.busy",   32'(bus.busy),   32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.sel_en) saw_done = 1'b1;
        end
        check_eq("midrst.quiet_after_release", 32'(saw_done), 32'd0);
        model_sel = '0;

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      m = 8'h00;
            else if (r == 1) m = 8'h01 << $urandom_range(0, 7);
            else             m = 8'($urandom);
            dw = $urandom_range(0, 4);
            c  = 1'($urandom_range(0, 1));
            if (c) sa = $urandom_range(1, 30);
            else   sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
            run_scan(m, dw, c, sa, $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
